// File: rtl/sw_debouncer_pkg.sv
// sw_debouncer_pkg: shared constants and counter sizing helper for the switch debouncer
package sw_debouncer_pkg;
   localparam int SW_WIDTH             = 16;
   localparam int DEFAULT_TICK_DIV     = 100000;
   localparam int DEFAULT_STABLE_TICKS = 10;
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: accepts a new level once it has persisted for STABLE_TICKS consecutive ticks
module debounce_bit
   import sw_debouncer_pkg::*;
#(
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic in_sync,
   output logic out_clean,
   output logic changed
);
   localparam int CW = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
   logic [CW-1:0] cnt;
   // any return to the accepted level clears qualification; ticks advance it
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         out_clean <= 1'b0;
         changed   <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (in_sync == out_clean) cnt <= '0;
         else if (tick && cnt == LAST) begin
            out_clean <= in_sync;
            cnt       <= '0;
            changed   <= 1'b1;
         end else if (tick) cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: synchronizes and debounces the slide-switch bus, with per-bit change strobes
module sw_debouncer
   import sw_debouncer_pkg::*;
#(
   parameter int WIDTH        = SW_WIDTH,
   parameter int TICK_DIV     = DEFAULT_TICK_DIV,
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_changed,
   output logic             tick
);
   localparam int PW = cnt_width(TICK_DIV);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
   logic [WIDTH-1:0] sync1, sync2;
   logic [PW-1:0]    pcnt;
   // two-flop synchronizer; only sync2 feeds the debounce logic
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end
   // prescaler wrapping at TICK_DIV-1 with a registered tick strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else begin
         pcnt <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
         tick <= (pcnt == PLAST);
      end
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .in_sync  (sync2[i]),
         .out_clean(sw_clean[i]),
         .changed  (sw_changed[i])
      );
   end
endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer: three debouncer configurations checked against a tick-counting model plus literal timing checks
module tb_sw_debouncer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] sw_raw = 16'hFFFF;
   logic [15:0] clean_a, chg_a, clean_b, chg_b, clean_c, chg_c;
   logic tick_a, tick_b, tick_c;
   int checks = 0;
   int failures = 0;
   int td [3] = '{1, 4, 1};
   int st [3] = '{3, 2, 5};
   int m_n [3];
   logic [15:0] m_s1 [3], m_s2 [3], m_clean [3], m_chg [3];
   logic m_tk [3];
   int m_run [3][16];

   always #5 clk = ~clk;

   sw_debouncer #(.WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(3)) dut_a (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_clean(clean_a), .sw_changed(chg_a), .tick(tick_a));
   sw_debouncer #(.WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(2)) dut_b (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_clean(clean_b), .sw_changed(chg_b), .tick(tick_b));
   sw_debouncer #(.WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(5)) dut_c (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_clean(clean_c), .sw_changed(chg_c), .tick(tick_c));

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   // model: raw is seen two edges late; a bit flips on the tick that completes a run of
   // STABLE_TICKS ticks during which the synchronized level differed from the accepted one
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_n[d] = 0; m_s1[d] = '0; m_s2[d] = '0; m_clean[d] = '0; m_chg[d] = '0; m_tk[d] = 1'b0;
            for (int i = 0; i < 16; i++) m_run[d][i] = 0;
         end else begin
            m_chg[d] = '0;
            for (int i = 0; i < 16; i++) begin
               if (m_s2[d][i] == m_clean[d][i]) m_run[d][i] = 0;
               else if (m_tk[d]) begin
                  m_run[d][i]++;
                  if (m_run[d][i] == st[d]) begin
                     m_clean[d][i] = m_s2[d][i];
                     m_chg[d][i] = 1'b1;
                     m_run[d][i] = 0;
                  end
               end
            end
            m_s2[d] = m_s1[d];
            m_s1[d] = sw_raw;
            m_n[d]++;
            m_tk[d] = (m_n[d] % td[d] == 0);
         end
      end
   end

   // every-cycle comparison of all three DUTs against the model
   always @(posedge clk) begin
      #1;
      chk("clean_a", clean_a, m_clean[0]);
      chk("chg_a", chg_a, m_chg[0]);
      chk("tick_a", {15'd0, tick_a}, {15'd0, m_tk[0]});
      chk("clean_b", clean_b, m_clean[1]);
      chk("chg_b", chg_b, m_chg[1]);
      chk("tick_b", {15'd0, tick_b}, {15'd0, m_tk[1]});
      chk("clean_c", clean_c, m_clean[2]);
      chk("chg_c", chg_c, m_chg[2]);
      chk("tick_c", {15'd0, tick_c}, {15'd0, m_tk[2]});
   end

   task automatic edges(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic [15:0] v);
      @(negedge clk);
      sw_raw = v;
      repeat (30) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int cnt, k;
      logic [15:0] c;
      for (int j = 0; j < 3; j++) begin
         edges(1);
         chk("rst_clean", clean_a, 16'h0);
         chk("rst_chg", chg_a, 16'h0);
         chk("rst_tick", {15'd0, tick_a}, 16'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      edges(4);
      chk("rel_clean_e4", clean_a, 16'h0);
      edges(1);
      chk("rel_clean_e5", clean_a, 16'hFFFF);
      chk("rel_chg_e5", chg_a, 16'hFFFF);
      edges(1);
      chk("rel_chg_e6", chg_a, 16'h0);

      settle(16'h0000);
      sw_raw = 16'h4000;
      edges(4);
      chk("lat14_e4", clean_a, 16'h0);
      edges(1);
      chk("lat14_e5", clean_a, 16'h4000);
      chk("lat14_chg", chg_a, 16'h4000);
      edges(1);
      chk("lat14_chg_off", chg_a, 16'h0);

      settle(16'h0000);
      for (int j = 0; j < 8; j++) begin
         sw_raw = (j % 2 == 0) ? 16'h0001 : 16'h0000;
         edges(1);
         chk("bounce_hold", clean_a & 16'h0001, 16'h0);
         @(negedge clk);
      end
      sw_raw = 16'h0001;
      edges(4);
      chk("bounce_e4", clean_a & 16'h0001, 16'h0);
      edges(1);
      chk("bounce_e5", clean_a, 16'h0001);
      chk("bounce_chg", chg_a, 16'h0001);
      edges(1);
      chk("bounce_chg_off", chg_a, 16'h0);

      settle(16'h0000);
      cnt = 0;
      for (int j = 0; j < 12; j++) begin
         edges(1);
         cnt += int'(tick_b);
      end
      chk("presc_ticks", 16'(cnt), 16'd3);
      @(negedge clk);
      sw_raw = 16'h8000;
      k = 0;
      while (k < 20 && clean_b[15] !== 1'b1) begin
         edges(1);
         k++;
      end
      chk("presc_lat_ok", {15'd0, k >= 7 && k <= 10}, 16'd1);

      settle(16'h0000);
      sw_raw = 16'h0004;
      edges(4);
      @(negedge clk);
      rst = 1'b1;
      edges(1);
      chk("midrst_clean", clean_c, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      edges(6);
      chk("midrst_e6", clean_c, 16'h0);
      edges(1);
      chk("midrst_e7", clean_c, 16'h0004);

      settle(16'hC008);
      chk("mux_clean", clean_a, 16'hC008);
      c = clean_a;
      chk("mux_led_on", {15'd0, c[c[15:14]]}, 16'd1);
      sw_raw = 16'hC000;
      edges(4);
      c = clean_a;
      chk("mux_led_e4", {15'd0, c[c[15:14]]}, 16'd1);
      edges(1);
      c = clean_a;
      chk("mux_led_e5", {15'd0, c[c[15:14]]}, 16'd0);

      for (int j = 0; j < 3000; j++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 3) == 0) sw_raw = sw_raw ^ (16'd1 << $urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) sw_raw = 16'($urandom);
      end
      @(negedge clk);
      rst = 1'b0;
      edges(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
